// File: rtl/spk_out_mc_if.sv
// spk_out_mc_if: fire handshake, credit return and spike flit output of spk_out_mc
interface spk_out_mc_if #(parameter int FW = 59, SW = 24, DST_DEPTH = 4);
  logic fire_vld;
  logic [SW-1:0] fire_neuid;
  logic [DST_DEPTH-1:0] fire_ptr;
  logic fire_rdy;
  logic credit_in;
  logic flit_out_wr;
  logic [FW-1:0] flit_out;
  modport master (output fire_vld, fire_neuid, fire_ptr, credit_in, input fire_rdy, flit_out_wr, flit_out);
  modport slave (input fire_vld, fire_neuid, fire_ptr, credit_in, output fire_rdy, flit_out_wr, flit_out);
endinterface

// File: rtl/spk_out_mc.sv
// spk_out_mc: multicast spike-output engine (fire FIFO, destination-table walk, credit flow control); SPK_OUT_PREFETCH_EN gives 1 flit/cycle walks
module spk_out_mc #(
  parameter int FW = 59,
  parameter int FTW = 3,
  parameter int SW = 24,
  parameter int DST_WIDTH = 21,
  parameter int DST_DEPTH = 4,
  parameter int FQ_AW = 3,
  parameter int CREDIT_NUM = 4,
  parameter int CW = 3,
  parameter logic [FTW-1:0] FTYPE_SPK = '0
)(
  input  logic clk,
  input  logic rst,
  spk_out_mc_if.slave io,
  input  logic tbl_we,
  input  logic [DST_DEPTH-1:0] tbl_waddr,
  input  logic [DST_WIDTH-1:0] tbl_wdata,
  input  logic tbl_re,
  input  logic [DST_DEPTH-1:0] tbl_raddr,
  output logic [DST_WIDTH-1:0] tbl_rdata,
  output logic busy
);
  localparam int LW = FW - FTW - (DST_WIDTH - 1) - SW;
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  state_t state;
  logic [DST_WIDTH-1:0] tbl [2**DST_DEPTH];
  logic [SW+DST_DEPTH-1:0] fq [2**FQ_AW];
  logic [FQ_AW:0] wp, rp;
  logic [SW-1:0] neuid;
  logic [DST_DEPTH-1:0] cur_ptr;
  logic [DST_WIDTH-1:0] ent;
  logic [CW-1:0] credit;
  logic empty, full, push, send, last;
  assign empty = wp == rp;
  assign full = (wp[FQ_AW] != rp[FQ_AW]) && (wp[FQ_AW-1:0] == rp[FQ_AW-1:0]);
  assign io.fire_rdy = !full;
  assign push = io.fire_vld && !full;
  assign send = state == SEND && credit != '0;
  assign last = ent[0] || cur_ptr == {DST_DEPTH{1'b1}};
  assign busy = !empty || state != IDLE;
  always_ff @(posedge clk) if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
  always_ff @(posedge clk) if (push) fq[wp[FQ_AW-1:0]] <= {io.fire_neuid, io.fire_ptr};
  // the single table read port is shared; a config read wins and the walk waits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      credit <= CW'(CREDIT_NUM);
      io.flit_out_wr <= 1'b0;
      io.flit_out <= '0;
      tbl_rdata <= '0;
      neuid <= '0;
      cur_ptr <= '0;
      ent <= '0;
    end else begin
      io.flit_out_wr <= send;
      if (send) io.flit_out <= FW'({FTYPE_SPK, ent[DST_WIDTH-1:1], neuid}) << LW;
      if (push) wp <= wp + 1'b1;
      if (tbl_re) tbl_rdata <= tbl[tbl_raddr];
      credit <= (send && !io.credit_in) ? credit - 1'b1 :
                (!send && io.credit_in && credit != CW'(CREDIT_NUM)) ? credit + 1'b1 : credit;
      case (state)
        IDLE: if (!empty) begin
          {neuid, cur_ptr} <= fq[rp[FQ_AW-1:0]];
          rp <= rp + 1'b1;
          state <= FETCH;
        end
        FETCH: if (!tbl_re) begin
          ent <= tbl[cur_ptr];
          state <= SEND;
        end
        SEND: if (send) begin
          if (last) state <= IDLE;
          else begin
            cur_ptr <= cur_ptr + 1'b1;
`ifdef SPK_OUT_PREFETCH_EN
            if (!tbl_re) ent <= tbl[cur_ptr + 1'b1];
            else state <= FETCH;
`else
            state <= FETCH;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spk_out_mc.sv
// tb_spk_out_mc: directed self-checking bench for spk_out_mc
module tb_spk_out_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic tbl_we = 1'b0, tbl_re = 1'b0;
  logic [3:0] tbl_waddr = '0, tbl_raddr = '0;
  logic [20:0] tbl_wdata = '0;
  logic [20:0] tbl_rdata;
  logic busy;
  spk_out_mc_if io();
  spk_out_mc dut (.clk(clk), .rst(rst), .io(io), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
                  .tbl_re(tbl_re), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata), .busy(busy));
`ifdef SPK_OUT_PREFETCH_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 2;
`endif
  localparam logic [63:0] ST_SEND = 64'd2;
  int tests = 0, fails = 0, cyc = 0;
  int t, e, base, acc, n;
  logic [58:0] fl[$];
  int fc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) if (io.flit_out_wr) begin fl.push_back(io.flit_out); fc.push_back(cyc); end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  function automatic logic [58:0] spk(input logic [19:0] h, input logic [23:0] nid);
    return {3'b000, h, nid, 12'h000};
  endfunction
  task automatic wr(input logic [3:0] a, input logic [19:0] h, input logic l);
    tbl_we = 1'b1; tbl_waddr = a; tbl_wdata = {h, l}; tick(); tbl_we = 1'b0;
  endtask
  task automatic fire(input logic [23:0] nid, input logic [3:0] p, output int tt);
    io.fire_vld = 1'b1; io.fire_neuid = nid; io.fire_ptr = p; tick(); io.fire_vld = 1'b0; tt = cyc;
  endtask
  task automatic wait_flits(input int k, input string tag);
    int b = 0;
    while (fl.size() < k && b < 40) begin tick(); b++; end
    chk(tag, 64'(fl.size()), 64'(k));
  endtask
  task automatic pulse(input int k);
    io.credit_in = 1'b1; tick(k); io.credit_in = 1'b0;
  endtask
  initial begin
    io.fire_vld = 1'b0; io.fire_neuid = '0; io.fire_ptr = '0; io.credit_in = 1'b0;
    tick(3);
    chk("rst_flit_wr", 64'(io.flit_out_wr), 0);
    chk("rst_flit", 64'(io.flit_out), 0);
    chk("rst_rdata", 64'(tbl_rdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_fire_rdy", 64'(io.fire_rdy), 1);
    chk("rst_credit", 64'(dut.credit), 4);
    rst = 1'b0;
    wr(2, 20'h00A5, 1); wr(5, 20'h0B05, 0); wr(6, 20'h0B06, 0); wr(7, 20'h0B07, 1);
    wr(15, 20'h0F0F, 0); wr(0, 20'h00F0, 1);
    for (int i = 8; i < 15; i++) wr(4'(i), 20'(32'h100 + i), 1);
    fire(24'h123456, 2, t);
    wait_flits(1, "t1_count");
    chk("t1_flit", 64'(fl[0]), 64'(spk(20'h00A5, 24'h123456)));
    chk("t1_cycle", 64'(fc[0]), 64'(t + 3));
    chk("t1_credit", 64'(dut.credit), 3);
    pulse(1); tick(2);
    base = fl.size();
    fire(24'hABCDEF, 5, t);
    wait_flits(base + 3, "t2_count");
    for (int i = 0; i < 3; i++) begin
      chk("t2_flit", 64'(fl[base+i]), 64'(spk(20'(32'h0B05 + i), 24'hABCDEF)));
      chk("t2_cycle", 64'(fc[base+i]), 64'(t + 3 + i * STEP));
    end
    tick(3);
    chk("t2_busy", 64'(busy), 0);
    chk("t2_no_extra", 64'(fl.size()), 64'(base + 3));
    chk("t2_credit", 64'(dut.credit), 1);
    pulse(3);
    base = fl.size();
    io.fire_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin io.fire_neuid = 24'(32'h10 + i); io.fire_ptr = 2; tick(); end
    io.fire_vld = 1'b0;
    tick(40);
    chk("t3_four", 64'(fl.size()), 64'(base + 4));
    chk("t3_credit0", 64'(dut.credit), 0);
    chk("t3_hold", 64'(dut.state), ST_SEND);
    chk("t3_busy", 64'(busy), 1);
    io.credit_in = 1'b1; tick(); e = cyc; tick(); io.credit_in = 1'b0;
    chk("t3_same_cycle", 64'(dut.credit), 1);
    tick();
    chk("t3_fifth", 64'(fl.size()), 64'(base + 5));
    chk("t3_fifth_cycle", 64'(fc[base+4]), 64'(e + 1));
    tick(5);
    chk("t3_sixth", 64'(fl.size()), 64'(base + 6));
    chk("t3_credit_end", 64'(dut.credit), 0);
    for (int i = 0; i < 6; i++) chk("t3_order", 64'(fl[base+i]), 64'(spk(20'h00A5, 24'(32'h10 + i))));
    fire(24'h000020, 8, t);
    tick(5);
    chk("t4_stalled", 64'(dut.state), ST_SEND);
    base = fl.size();
    acc = 0;
    io.fire_vld = 1'b1;
    for (int i = 0; i < 9; i++) begin
      io.fire_neuid = 24'(32'h30 + i); io.fire_ptr = 4'(8 + i % 7);
      if (io.fire_rdy) acc++;
      tick();
    end
    io.fire_vld = 1'b0;
    chk("t4_accepted", 64'(acc), 8);
    chk("t4_full", 64'(io.fire_rdy), 0);
    chk("t4_none_sent", 64'(fl.size()), 64'(base));
    io.credit_in = 1'b1; tick(40); io.credit_in = 1'b0; tick(2);
    chk("t4_total", 64'(fl.size()), 64'(base + 9));
    chk("t4_first", 64'(fl[base]), 64'(spk(20'h0108, 24'h000020)));
    for (int i = 0; i < 8; i++)
      chk("t4_order", 64'(fl[base+1+i]), 64'(spk(20'(32'h108 + i % 7), 24'(32'h30 + i))));
    chk("t4_credit_cap", 64'(dut.credit), 4);
    chk("t4_busy", 64'(busy), 0);
    chk("t4_rdy", 64'(io.fire_rdy), 1);
    base = fl.size();
    fire(24'h777777, 15, t);
    tick(15);
    chk("t5_count", 64'(fl.size()), 64'(base + 1));
    chk("t5_flit", 64'(fl[base]), 64'(spk(20'h0F0F, 24'h777777)));
    chk("t5_busy", 64'(busy), 0);
    pulse(1);
    fire(24'h555555, 5, t);
    tick(3);
    chk("t6_first_wr", 64'(io.flit_out_wr), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_wr", 64'(io.flit_out_wr), 0);
    chk("t6_rst_rdy", 64'(io.fire_rdy), 1);
    chk("t6_rst_credit", 64'(dut.credit), 4);
    chk("t6_rst_busy", 64'(busy), 0);
    n = fl.size();
    tick(10);
    chk("t6_no_more", 64'(fl.size()), 64'(n));
    tbl_re = 1'b1; tbl_raddr = 2; tick(); tbl_re = 1'b0;
    chk("t6_read2", 64'(tbl_rdata), 64'({20'h00A5, 1'b1}));
    tbl_re = 1'b1; tbl_raddr = 15; tick(); tbl_re = 1'b0;
    chk("t6_read15", 64'(tbl_rdata), 64'({20'h0F0F, 1'b0}));
    tbl_re = 1'b1; tbl_raddr = 6; tbl_we = 1'b1; tbl_waddr = 6; tbl_wdata = {20'hC006, 1'b1}; tick();
    tbl_we = 1'b0;
    chk("t7_old_data", 64'(tbl_rdata), 64'({20'h0B06, 1'b0}));
    tick(); tbl_re = 1'b0;
    chk("t7_new_data", 64'(tbl_rdata), 64'({20'hC006, 1'b1}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
